mux2x1: RTL and testbench

- 2:1 selector with built-in switching-activity monitor for the power-estimation flow.
- Datapath is purely combinational: `out` follows `a` when `sel`=0 and `b` when `sel`=1.
- A clocked side-block keeps a registered copy of `out` and saturating toggle counters for every input and the output.
- The estimator reads these counters as per-net activity factors.

---
 rtl/mux2x1.sv | 80 ++++++++
 tb/tb_mux2x1.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux2x1.sv
// 2:1 selector with a clocked switching-activity monitor.
// out is purely combinational; out_q and the saturating toggle/cycle counters are registered.
module mux2x1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] tgl_a,
  output logic [CNT_W-1:0] tgl_b,
  output logic [CNT_W-1:0] tgl_sel,
  output logic [CNT_W-1:0] tgl_out,
  output logic [CNT_W-1:0] cyc_cnt
);

  logic [WIDTH-1:0] pa;
  logic [WIDTH-1:0] pb;
  logic [WIDTH-1:0] pout;
  logic             psel;
  logic             primed;

  assign out = sel ? b : a;

  function automatic logic [CNT_W:0] popcount(input logic [WIDTH-1:0] x);
    logic [CNT_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{CNT_W{1'b0}}, x[i]};
    end
    return c;
  endfunction

  // Any carry into the top two bits means the true sum exceeds all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [CNT_W:0]   inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, acc} + {1'b0, inc};
    if (sum[CNT_W+1:CNT_W] != 2'b00) begin
      return '1;
    end
    return sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      pa      <= '0;
      pb      <= '0;
      psel    <= 1'b0;
      pout    <= '0;
      primed  <= 1'b0;
      tgl_a   <= '0;
      tgl_b   <= '0;
      tgl_sel <= '0;
      tgl_out <= '0;
      cyc_cnt <= '0;
    end else begin
      out_q  <= out;
      pa     <= a;
      pb     <= b;
      psel   <= sel;
      pout   <= out;
      primed <= 1'b1;
      // The first edge after reset only captures the baseline samples.
      if (primed) begin
        tgl_a   <= sat_add(tgl_a, popcount(a ^ pa));
        tgl_b   <= sat_add(tgl_b, popcount(b ^ pb));
        tgl_sel <= sat_add(tgl_sel, {{CNT_W{1'b0}}, sel ^ psel});
        tgl_out <= sat_add(tgl_out, popcount(out ^ pout));
        cyc_cnt <= sat_add(cyc_cnt, {{CNT_W{1'b0}}, 1'b1});
      end
    end
  end

endmodule

// File: tb/tb_mux2x1.sv
// Directed bench for mux2x1: default, narrow-counter (CNT_W=3) and 4-bit-wide instances
// share one clock and reset; every check is an immediate assertion against a hand value.
module tb_mux2x1;

  logic clk;
  logic clk_en;
  logic rst;

  // d0: WIDTH=1, CNT_W=16
  logic a0, b0, sel0, out0, out_q0;
  logic [15:0] tgl_a0, tgl_b0, tgl_sel0, tgl_out0, cyc0;
  // d1: WIDTH=1, CNT_W=3
  logic a1, b1, sel1, out1, out_q1;
  logic [2:0] tgl_a1, tgl_b1, tgl_sel1, tgl_out1, cyc1;
  // d2: WIDTH=4, CNT_W=16
  logic [3:0] a2, b2, out2, out_q2;
  logic sel2;
  logic [15:0] tgl_a2, tgl_b2, tgl_sel2, tgl_out2, cyc2;

  int n_checks;
  int n_fail;

  mux2x1 #(.WIDTH(1), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .sel(sel0), .out(out0), .out_q(out_q0),
    .tgl_a(tgl_a0), .tgl_b(tgl_b0), .tgl_sel(tgl_sel0), .tgl_out(tgl_out0), .cyc_cnt(cyc0)
  );

  mux2x1 #(.WIDTH(1), .CNT_W(3)) d1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1), .out(out1), .out_q(out_q1),
    .tgl_a(tgl_a1), .tgl_b(tgl_b1), .tgl_sel(tgl_sel1), .tgl_out(tgl_out1), .cyc_cnt(cyc1)
  );

  mux2x1 #(.WIDTH(4), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .sel(sel2), .out(out2), .out_q(out_q2),
    .tgl_a(tgl_a2), .tgl_b(tgl_b2), .tgl_sel(tgl_sel2), .tgl_out(tgl_out2), .cyc_cnt(cyc2)
  );

  // Clock stays parked low until the combinational phase is done.
  initial begin
    clk = 1'b0;
    wait (clk_en === 1'b1);
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input logic a, input logic b, input logic s, input logic exp, input string tag);
    a0 = a; b0 = b; sel0 = s;
    #1;
    check(tag, 32'(out0), 32'(exp));
  endtask

  task automatic check_d0(input string tag, input logic oq, input int ta, input int tb,
                          input int ts, input int to, input int cy);
    check({tag, "_out_q"},   32'(out_q0),   32'(oq));
    check({tag, "_tgl_a"},   32'(tgl_a0),   32'(ta));
    check({tag, "_tgl_b"},   32'(tgl_b0),   32'(tb));
    check({tag, "_tgl_sel"}, 32'(tgl_sel0), 32'(ts));
    check({tag, "_tgl_out"}, 32'(tgl_out0), 32'(to));
    check({tag, "_cyc"},     32'(cyc0),     32'(cy));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
    a2 = 4'h0; b2 = 4'h0; sel2 = 1'b0;

    // Combinational truth table with no clock edges at all.
    comb(1'b0, 1'b1, 1'b0, 1'b0, "comb_a0b1s0");
    comb(1'b1, 1'b0, 1'b1, 1'b0, "comb_a1b0s1");
    comb(1'b1, 1'b0, 1'b0, 1'b1, "comb_a1b0s0");
    comb(1'b1, 1'b1, 1'b1, 1'b1, "comb_a1b1s1");
    comb(1'b0, 1'b1, 1'b1, 1'b1, "comb_a0b1s1");
    comb(1'b1, 1'b0, 1'b0, 1'b1, "comb_a1b0s0_again");
    a2 = 4'b1100; b2 = 4'b0011; sel2 = 1'b1;
    #1;
    check("comb_w4_sel1", 32'(out2), 32'h3);
    sel2 = 1'b0;
    #1;
    check("comb_w4_sel0", 32'(out2), 32'hC);

    // Reset for two edges with random inputs.
    clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a0 = 1'($urandom_range(0, 1)); b0 = 1'($urandom_range(0, 1)); sel0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1)); sel1 = 1'($urandom_range(0, 1));
      a2 = 4'($urandom_range(0, 15)); sel2 = 1'($urandom_range(0, 1));
      tick();
    end
    check_d0("reset", 1'b0, 0, 0, 0, 0, 0);
    check("reset_d1_tgl_sel", 32'(tgl_sel1), 32'd0);
    check("reset_d1_cyc",     32'(cyc1),     32'd0);
    check("reset_d2_out_q",   32'(out_q2),   32'd0);
    check("reset_d2_tgl_a",   32'(tgl_a2),   32'd0);

    // Priming edge: baseline only.
    rst = 1'b0;
    a0 = 1'b0; b0 = 1'b1; sel0 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
    a2 = 4'b0000; b2 = 4'b0000; sel2 = 1'b0;
    tick();
    check_d0("prime", 1'b0, 0, 0, 0, 0, 0);
    check("prime_d1_cyc", 32'(cyc1), 32'd0);
    check("prime_d2_cyc", 32'(cyc2), 32'd0);

    // First counting edge.
    a0 = 1'b1; b0 = 1'b0; sel0 = 1'b1;
    a2 = 4'b1011;
    tick();
    check_d0("count1", 1'b0, 1, 1, 1, 0, 1);
    check("w4_tgl_a",   32'(tgl_a2),   32'd3);
    check("w4_tgl_out", 32'(tgl_out2), 32'd3);
    check("w4_tgl_b",   32'(tgl_b2),   32'd0);
    check("w4_cyc",     32'(cyc2),     32'd1);
    check("w4_out_q",   32'(out_q2),   32'hB);
    check("d1_cyc_held_sel", 32'(cyc1), 32'd1);

    // Toggle sel on the narrow instance; 1011 -> 0100 flips all four bits on d2.
    a2 = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      sel1 = ~sel1;
      tick();
    end
    check("sat_mid_tgl_sel", 32'(tgl_sel1), 32'd5);
    check("sat_mid_cyc",     32'(cyc1),     32'd6);
    check("w4_tgl_a_total",  32'(tgl_a2),   32'd7);
    check("w4_tgl_out_total", 32'(tgl_out2), 32'd7);
    for (int i = 0; i < 5; i++) begin
      sel1 = ~sel1;
      tick();
    end
    check("sat_tgl_sel", 32'(tgl_sel1), 32'd7);
    check("sat_cyc",     32'(cyc1),     32'd7);
    check("sat_tgl_out", 32'(tgl_out1), 32'd0);
    check("sat_tgl_a",   32'(tgl_a1),   32'd0);
    check_d0("held", 1'b0, 1, 1, 1, 0, 11);

    // Mid-run reset for one edge.
    rst = 1'b1;
    tick();
    check_d0("midrst", 1'b0, 0, 0, 0, 0, 0);
    check("midrst_d1_tgl_sel", 32'(tgl_sel1), 32'd0);
    check("midrst_d1_cyc",     32'(cyc1),     32'd0);
    check("midrst_d2_tgl_a",   32'(tgl_a2),   32'd0);

    // Re-prime edge with inputs changed from before the reset: nothing counts.
    rst = 1'b0;
    a0 = 1'b0; b0 = 1'b1; sel0 = 1'b0;
    tick();
    check_d0("reprime", 1'b0, 0, 0, 0, 0, 0);

    // Counting resumes: a and out go 0 -> 1.
    a0 = 1'b1;
    tick();
    check_d0("resume", 1'b1, 1, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
